// File: rtl/bus_arb_ctl.sv
// Bus arbiter with grant lock until accept and 1-cycle read return.
// Grant selection is fixed priority (highest index) or round-robin.
module bus_arb_ctl #(
    parameter int NUM_CH = 3,
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RR_EN  = 0
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic [NUM_CH-1:0]    req_ch,
    input  logic [NUM_CH*AW-1:0] addr_ch,
    input  logic [NUM_CH*DW-1:0] wdata_ch,
    input  logic [NUM_CH-1:0]    wen_ch,
    input  logic                 mem_ready_top,
    input  logic [DW-1:0]        mem_rdata_top,
    output logic [AW-1:0]        mem_addr_ctl,
    output logic [DW-1:0]        mem_wdata_ctl,
    output logic                 mem_wen_ctl,
    output logic                 mem_cs_en_ctl,
    output logic [NUM_CH-1:0]    grant_ch,
    output logic [NUM_CH-1:0]    hold_ch,
    output logic [NUM_CH*DW-1:0] rdata_ch,
    output logic [NUM_CH-1:0]    rvalid_ch
);

    localparam int IW = $clog2(NUM_CH);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_e;

    state_e        st_q, st_d;
    logic [IW-1:0] lock_ch_q, lock_ch_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] rsp_ch_q, rsp_ch_d;
    logic          rsp_vld_q, rsp_vld_d;

    logic [IW-1:0] pick;
    logic          any;
    logic          gnt_vld;
    logic          accept;

    // Grant selection: a live lock wins, otherwise arbitrate fresh.
    always_comb begin
        int idx;
        pick = '0;
        any  = 1'b0;
        idx  = 0;
        if (st_q == ST_LOCKED && req_ch[lock_ch_q]) begin
            pick = lock_ch_q;
            any  = 1'b1;
        end else if (RR_EN != 0) begin
            // Walk downward so the nearest slot after rr_ptr wins last.
            for (int k = NUM_CH; k >= 1; k--) begin
                idx = (int'(rr_ptr_q) + k) % NUM_CH;
                if (req_ch[idx]) begin
                    pick = IW'(idx);
                    any  = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (req_ch[i]) begin
                    pick = IW'(i);
                    any  = 1'b1;
                end
            end
        end
    end

    assign gnt_vld = any & rst_b;
    assign accept  = gnt_vld & mem_ready_top;

    assign grant_ch      = gnt_vld ? (NUM_CH'(1) << pick) : '0;
    assign mem_cs_en_ctl = |grant_ch;
    assign mem_addr_ctl  = gnt_vld ? addr_ch[int'(pick)*AW +: AW] : '0;
    assign mem_wdata_ctl = gnt_vld ? wdata_ch[int'(pick)*DW +: DW] : '0;
    assign mem_wen_ctl   = gnt_vld & wen_ch[pick];

    assign hold_ch = rst_b
                   ? (req_ch & ~(grant_ch & {NUM_CH{mem_ready_top}}))
                   : '0;

    assign rvalid_ch = rsp_vld_q ? (NUM_CH'(1) << rsp_ch_q) : '0;

    // Route read data only to the channel owning the response.
    always_comb begin
        rdata_ch = '0;
        if (rsp_vld_q) begin
            rdata_ch[int'(rsp_ch_q)*DW +: DW] = mem_rdata_top;
        end
    end

    // Next state: lock on a stalled grant, track rr_ptr and read return.
    always_comb begin
        st_d      = ST_IDLE;
        lock_ch_d = lock_ch_q;
        rr_ptr_d  = rr_ptr_q;
        rsp_vld_d = 1'b0;
        rsp_ch_d  = rsp_ch_q;
        if (gnt_vld && !mem_ready_top) begin
            st_d      = ST_LOCKED;
            lock_ch_d = pick;
        end
        if (accept) begin
            if (RR_EN != 0) begin
                rr_ptr_d = pick;
            end
            rsp_vld_d = ~wen_ch[pick];
            rsp_ch_d  = pick;
        end
    end

    // State registers; reset drops any lock and pending response.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            st_q      <= ST_IDLE;
            lock_ch_q <= '0;
            rr_ptr_q  <= IW'(NUM_CH - 1);
            rsp_vld_q <= 1'b0;
            rsp_ch_q  <= '0;
        end else begin
            st_q      <= st_d;
            lock_ch_q <= lock_ch_d;
            rr_ptr_q  <= rr_ptr_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_ch_q  <= rsp_ch_d;
        end
    end

endmodule

// File: tb/tb_bus_arb_ctl.sv
// Scoreboard bench for bus_arb_ctl: fixed-priority and round-robin
// instances share stimulus; a negedge monitor pops expectations.
module tb_bus_arb_ctl;

    logic        clk;
    logic        rst_b;
    logic [2:0]  req;
    logic [2:0]  wen;
    logic        ready;
    logic [31:0] rdata;
    logic [95:0] addr_v;
    logic [95:0] wdata_v;

    logic [31:0] f_addr, f_wdata, r_addr, r_wdata;
    logic        f_wen, f_cs, r_wen, r_cs;
    logic [2:0]  f_grant, f_hold, f_rvalid;
    logic [2:0]  r_grant, r_hold, r_rvalid;
    logic [95:0] f_rdata, r_rdata;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  fg;
        logic [2:0]  fh;
        logic [2:0]  rg;
        logic [2:0]  rh;
        logic [31:0] faddr;
        logic        fwen;
    } req_exp_t;

    typedef struct {
        logic [2:0]  ch;
        logic [31:0] data;
    } rsp_exp_t;

    req_exp_t req_q[$];
    rsp_exp_t fq[$];
    rsp_exp_t rrq[$];
    req_exp_t me;
    rsp_exp_t mr;

    bus_arb_ctl #(.NUM_CH(3), .AW(32), .DW(32), .RR_EN(0)) u_fp (
        .clk(clk), .rst_b(rst_b), .req_ch(req), .addr_ch(addr_v),
        .wdata_ch(wdata_v), .wen_ch(wen), .mem_ready_top(ready),
        .mem_rdata_top(rdata), .mem_addr_ctl(f_addr),
        .mem_wdata_ctl(f_wdata), .mem_wen_ctl(f_wen),
        .mem_cs_en_ctl(f_cs), .grant_ch(f_grant), .hold_ch(f_hold),
        .rdata_ch(f_rdata), .rvalid_ch(f_rvalid)
    );

    bus_arb_ctl #(.NUM_CH(3), .AW(32), .DW(32), .RR_EN(1)) u_rr (
        .clk(clk), .rst_b(rst_b), .req_ch(req), .addr_ch(addr_v),
        .wdata_ch(wdata_v), .wen_ch(wen), .mem_ready_top(ready),
        .mem_rdata_top(rdata), .mem_addr_ctl(r_addr),
        .mem_wdata_ctl(r_wdata), .mem_wen_ctl(r_wen),
        .mem_cs_en_ctl(r_cs), .grant_ch(r_grant), .hold_ch(r_hold),
        .rdata_ch(r_rdata), .rvalid_ch(r_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [95:0] a,
                       input logic [95:0] x);
        checks++;
        if (a !== x) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", n, a, x);
        end
    endtask

    function automatic logic [31:0] chaddr(input logic [2:0] g);
        case (g)
            3'b001:  chaddr = 32'h040;
            3'b010:  chaddr = 32'h080;
            3'b100:  chaddr = 32'h100;
            default: chaddr = 32'h0;
        endcase
    endfunction

    function automatic logic [95:0] rsp_vec(input rsp_exp_t r);
        logic [95:0] v;
        v = '0;
        for (int i = 0; i < 3; i++) begin
            if (r.ch[i]) v[i*32 +: 32] = r.data;
        end
        return v;
    endfunction

    // Monitor: request-side records and read responses.
    always @(negedge clk) begin
        if (req_q.size() > 0) begin
            me = req_q.pop_front();
            chk("f_grant", 96'(f_grant), 96'(me.fg));
            chk("f_hold", 96'(f_hold), 96'(me.fh));
            chk("f_cs", 96'(f_cs), 96'(|me.fg));
            chk("f_addr", 96'(f_addr), 96'(me.faddr));
            chk("f_wen", 96'(f_wen), 96'(me.fwen));
            chk("r_grant", 96'(r_grant), 96'(me.rg));
            chk("r_hold", 96'(r_hold), 96'(me.rh));
            chk("r_cs", 96'(r_cs), 96'(|me.rg));
        end
        if (f_rvalid != 3'b000) begin
            if (fq.size() == 0) begin
                chk("f_rvalid_unexp", 96'(f_rvalid), 96'(0));
            end else begin
                mr = fq.pop_front();
                chk("f_rvalid", 96'(f_rvalid), 96'(mr.ch));
                chk("f_rdata", f_rdata, rsp_vec(mr));
            end
        end else begin
            chk("f_rdata_idle", f_rdata, 96'(0));
        end
        if (r_rvalid != 3'b000) begin
            if (rrq.size() == 0) begin
                chk("r_rvalid_unexp", 96'(r_rvalid), 96'(0));
            end else begin
                mr = rrq.pop_front();
                chk("r_rvalid", 96'(r_rvalid), 96'(mr.ch));
                chk("r_rdata", r_rdata, rsp_vec(mr));
            end
        end else begin
            chk("r_rdata_idle", r_rdata, 96'(0));
        end
    end

    task automatic step(input logic rb, input logic [2:0] rq,
                        input logic [2:0] wn, input logic rdy,
                        input logic [31:0] rd,
                        input logic [2:0] fg, input logic [2:0] fh,
                        input logic [2:0] rg, input logic [2:0] rh);
        req_exp_t e;
        rst_b = rb;
        req   = rq;
        wen   = wn;
        ready = rdy;
        rdata = rd;
        e.fg    = fg;
        e.fh    = fh;
        e.rg    = rg;
        e.rh    = rh;
        e.faddr = chaddr(fg);
        e.fwen  = |(fg & wn);
        req_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic exp_f(input logic [2:0] ch, input logic [31:0] d);
        rsp_exp_t r;
        r.ch   = ch;
        r.data = d;
        fq.push_back(r);
    endtask

    task automatic exp_r(input logic [2:0] ch, input logic [31:0] d);
        rsp_exp_t r;
        r.ch   = ch;
        r.data = d;
        rrq.push_back(r);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_b   = 1'b0;
        req     = '0;
        wen     = '0;
        ready   = 1'b0;
        rdata   = '0;
        addr_v  = {32'h100, 32'h080, 32'h040};
        wdata_v = {32'hA2, 32'hA1, 32'hA0};
        @(posedge clk);
        #1;
        // reset: everything forced low
        step(0, 3'b111, 3'b100, 1, 0, 3'b000, 3'b000, 3'b000, 3'b000);
        // fixed prio ch2 write; round-robin 001,010,100,001
        step(1, 3'b111, 3'b100, 1, 0, 3'b100, 3'b011, 3'b001, 3'b110);
        exp_r(3'b001, 32'h11111111);
        step(1, 3'b111, 3'b100, 1, 32'h11111111,
             3'b100, 3'b011, 3'b010, 3'b101);
        exp_r(3'b010, 32'h22222222);
        step(1, 3'b111, 3'b100, 1, 32'h22222222,
             3'b100, 3'b011, 3'b100, 3'b011);
        step(1, 3'b111, 3'b100, 1, 32'h33333333,
             3'b100, 3'b011, 3'b001, 3'b110);
        exp_r(3'b001, 32'h44444444);
        // ch0 stalled, lock holds against ch2
        step(1, 3'b001, 3'b000, 0, 32'h44444444,
             3'b001, 3'b001, 3'b001, 3'b001);
        step(1, 3'b001, 3'b000, 0, 0, 3'b001, 3'b001, 3'b001, 3'b001);
        step(1, 3'b101, 3'b000, 0, 0, 3'b001, 3'b101, 3'b001, 3'b101);
        step(1, 3'b101, 3'b000, 1, 0, 3'b001, 3'b100, 3'b001, 3'b100);
        exp_f(3'b001, 32'h55555555);
        exp_r(3'b001, 32'h55555555);
        step(1, 3'b101, 3'b000, 1, 32'h55555555,
             3'b100, 3'b001, 3'b100, 3'b001);
        exp_f(3'b100, 32'h66666666);
        exp_r(3'b100, 32'h66666666);
        // ch1 read, DEADBEEF return
        step(1, 3'b010, 3'b000, 1, 32'h66666666,
             3'b010, 3'b000, 3'b010, 3'b000);
        exp_f(3'b010, 32'hDEADBEEF);
        exp_r(3'b010, 32'hDEADBEEF);
        step(1, 3'b000, 3'b000, 1, 32'hDEADBEEF,
             3'b000, 3'b000, 3'b000, 3'b000);
        // locked ch1 drops req, ch0 takes over same cycle
        step(1, 3'b010, 3'b000, 0, 0, 3'b010, 3'b010, 3'b010, 3'b010);
        step(1, 3'b001, 3'b000, 0, 0, 3'b001, 3'b001, 3'b001, 3'b001);
        step(1, 3'b001, 3'b001, 1, 0, 3'b001, 3'b000, 3'b001, 3'b000);
        // lock ch1, accept read, then reset before the response
        step(1, 3'b011, 3'b000, 0, 0, 3'b010, 3'b011, 3'b010, 3'b011);
        step(1, 3'b011, 3'b000, 1, 0, 3'b010, 3'b001, 3'b010, 3'b001);
        step(0, 3'b011, 3'b000, 1, 32'hBAD0BAD0,
             3'b000, 3'b000, 3'b000, 3'b000);
        // after release, round-robin restarts at ch0
        step(1, 3'b111, 3'b000, 0, 0, 3'b100, 3'b111, 3'b001, 3'b111);
        step(1, 3'b111, 3'b000, 1, 0, 3'b100, 3'b011, 3'b001, 3'b110);
        exp_f(3'b100, 32'h77777777);
        exp_r(3'b001, 32'h77777777);
        step(1, 3'b000, 3'b000, 1, 32'h77777777,
             3'b000, 3'b000, 3'b000, 3'b000);
        step(1, 3'b000, 3'b000, 1, 0, 3'b000, 3'b000, 3'b000, 3'b000);
        @(posedge clk);
        #1;
        chk("req_q_drained", 96'(req_q.size()), 96'(0));
        chk("f_rsp_drained", 96'(fq.size()), 96'(0));
        chk("r_rsp_drained", 96'(rrq.size()), 96'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_arb_ctl.md
BUS_ARB_CTL -- requirements
Module: bus_arb_ctl

Interface
REQ-001 Parameter NUM_CH, default 3: number of bus requesters; legal range 2..8.
REQ-002 Parameter AW, default 32: address width.
REQ-003 Parameter DW, default 32: data width.
REQ-004 Parameter RR_EN, default 0: 0 selects fixed priority (highest index wins); 1 selects round-robin.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  main clock; all state updates on its rising edge.
REQ-007 rst_b  in  1  asynchronous active-low reset.
REQ-008 req_ch  in  NUM_CH  per-channel access request.
REQ-009 addr_ch  in  NUM_CH*AW  per-channel address; channel i occupies bits [i*AW +: AW].
REQ-010 wdata_ch  in  NUM_CH*DW  per-channel write data; packed the same way.
REQ-011 wen_ch  in  NUM_CH  per-channel write enable (1 = write, 0 = read).
REQ-012 mem_ready_top  in  1  memory accepts the presented request this cycle.
REQ-013 mem_rdata_top  in  DW  raw memory read data, valid one cycle after an accepted read.
REQ-014 mem_addr_ctl / mem_wdata_ctl / mem_wen_ctl / mem_cs_en_ctl  out  AW/DW/1/1  arbitrated memory request.
REQ-015 grant_ch  out  NUM_CH  one-hot grant for the current cycle.
REQ-016 hold_ch  out  NUM_CH  per-channel stall.
REQ-017 rdata_ch  out  NUM_CH*DW  per-channel read data.
REQ-018 rvalid_ch  out  NUM_CH  one-cycle read-data-valid pulse per channel.

Function
REQ-019 grant_ch SHALL be at most one-hot and SHALL be all-zero when no req_ch bit is set.
REQ-020 Grant selection with RR_EN=0: the highest-index requesting channel SHALL win.
REQ-021 Grant selection with RR_EN=1: the first requesting channel SHALL win, searching upward from rr_ptr+1 with modulo NUM_CH wrap.
REQ-022 When a grant is not accepted (mem_ready_top=0), the arbiter SHALL enter state LOCKED, recording the granted channel.
REQ-023 While LOCKED, the recorded channel SHALL keep the grant regardless of other requests.
REQ-024 LOCKED SHALL exit to IDLE in the cycle the locked request is accepted.
REQ-025 LOCKED SHALL also exit to IDLE if the locked channel drops req_ch; re-arbitration then occurs the same cycle.
REQ-026 The memory request outputs SHALL reflect the granted channel's address, write data and write enable.
REQ-027 mem_cs_en_ctl SHALL equal the OR of grant_ch.
REQ-028 When there is no grant, mem_addr_ctl, mem_wdata_ctl and mem_wen_ctl SHALL be 0.
REQ-029 An access is accepted when mem_cs_en_ctl & mem_ready_top is true.
REQ-030 On acceptance with RR_EN=1, rr_ptr SHALL update to the accepted channel index; rr_ptr SHALL NOT change otherwise.
REQ-031 hold_ch[i] SHALL equal req_ch[i] & ~(grant_ch[i] & mem_ready_top), combinationally.
REQ-032 An accepted read SHALL register the response channel and set rvalid_ch for exactly the following cycle.
REQ-033 An accepted write SHALL produce no rvalid.
REQ-034 Read latency SHALL be fixed at 1 cycle; back-to-back accepted reads SHALL yield back-to-back rvalid pulses with no bubble.
REQ-035 rdata_ch for the responding channel SHALL equal mem_rdata_top while its rvalid_ch=1.
REQ-036 rdata_ch for every other channel SHALL be all-zero.
REQ-037 A request and a response for different channels in the same cycle SHALL be independent.
REQ-038 rvalid_ch SHALL be at most one-hot.

Reset
REQ-039 While rst_b=0: state IDLE, rr_ptr = NUM_CH-1, locked channel = 0, rvalid_ch = 0.
REQ-040 While rst_b=0, grant_ch, mem_cs_en_ctl and hold_ch SHALL be forced to 0, and rdata_ch SHALL be 0.
REQ-041 A reset asserted mid-lock or mid-response SHALL discard the pending lock and the pending rvalid with no output pulse after release.
REQ-042 After rst_b deasserts, the first arbitration with RR_EN=1 SHALL favour channel 0.

Verification
REQ-043 Fixed priority, NUM_CH=3, ready=1, req_ch=3'b111, ch2 write addr 0x100 -> grant_ch=3'b100, mem_wen_ctl=1, hold_ch=3'b011, no rvalid next cycle.
REQ-044 Round-robin, ready=1, req_ch=3'b111 held 4 cycles after reset -> grants 001, 010, 100, 001.
REQ-045 ready=0 for 2 cycles with ch0 granted, then ch2 raises req -> grant stays 3'b001 until acceptance; ch2 is granted the cycle after.
REQ-046 ch1 read accepted, mem_rdata_top=0xDEADBEEF next cycle -> rvalid_ch=3'b010 for one cycle, ch1 rdata=0xDEADBEEF, other channels read 0.
REQ-047 rst_b pulsed low while LOCKED with a read outstanding -> no rvalid after release, grant recomputed from idle, rr_ptr=2.
REQ-048 Locked ch1 drops req while ready=0, ch0 requesting -> grant moves to 3'b001 the same cycle, state IDLE.
